// File: rtl/rob_retire_unit_if.sv
// Rename/writeback/retire bundle of the reorder buffer.
// master = pipeline side, slave = ROB side.
interface rob_retire_unit_if #(
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6
);
  logic                   alloc_valid;
  logic                   alloc_has_dest;
  logic [PREG_W-1:0]      alloc_dr_p;
  logic [PREG_W-1:0]      alloc_old_dr;
  logic                   alloc_ready;
  logic [IDX_W-1:0]       alloc_rob_num;
  logic                   cmpl0_valid;
  logic [IDX_W-1:0]       cmpl0_idx;
  logic                   cmpl1_valid;
  logic [IDX_W-1:0]       cmpl1_idx;
  logic [1:0]             retire_cnt;
  logic [PREG_W-1:0]      retire_dr_p0;
  logic [PREG_W-1:0]      retire_dr_p1;
  logic [(1<<PREG_W)-1:0] ROB_retire;
  logic                   rob_empty;

  modport master (
    output alloc_valid, alloc_has_dest,
    output alloc_dr_p, alloc_old_dr,
    output cmpl0_valid, cmpl0_idx,
    output cmpl1_valid, cmpl1_idx,
    input  alloc_ready, alloc_rob_num,
    input  retire_cnt, retire_dr_p0,
    input  retire_dr_p1, ROB_retire,
    input  rob_empty
  );

  modport slave (
    input  alloc_valid, alloc_has_dest,
    input  alloc_dr_p, alloc_old_dr,
    input  cmpl0_valid, cmpl0_idx,
    input  cmpl1_valid, cmpl1_idx,
    output alloc_ready, alloc_rob_num,
    output retire_cnt, retire_dr_p0,
    output retire_dr_p1, ROB_retire,
    output rob_empty
  );
endinterface

// File: rtl/rob_retire_unit.sv
// Circular reorder buffer: in-order alloc, out-of-order
// completion, dual in-order retire with freed-preg mask.
module rob_retire_unit #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6
) (
  input logic clk,
  input logic rstn,
  rob_retire_unit_if.slave rob_if
);
  localparam int NPREG = 1 << PREG_W;
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  hasd_q;
  logic [PREG_W-1:0] dr_q  [DEPTH];
  logic [PREG_W-1:0] old_q [DEPTH];

  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W-1:0]  head1;
  logic [IDX_W:0]    count_q, count_d;

  logic              alloc_ok;
  logic              r0, r1;
  logic [1:0]        cnt_q, cnt_d;
  logic [PREG_W-1:0] dr0_q, dr0_d;
  logic [PREG_W-1:0] dr1_q, dr1_d;
  logic [NPREG-1:0]  mask_q, mask_d;

  always_comb begin
    head1    = head_q + 1'b1;
    alloc_ok = rob_if.alloc_valid
             && (count_q != FULL);
    r0 = valid_q[head_q] && done_q[head_q];
    r1 = r0 && valid_q[head1]
            && done_q[head1];
    cnt_d = {1'b0, r0} + {1'b0, r1};
    dr0_d = r0 ? dr_q[head_q] : '0;
    dr1_d = r1 ? dr_q[head1]  : '0;

    // preg 0 is hardwired and never returns to the pool
    mask_d = '0;
    if (r0 && hasd_q[head_q]
        && (old_q[head_q] != '0))
      mask_d[old_q[head_q]] = 1'b1;
    if (r1 && hasd_q[head1]
        && (old_q[head1] != '0))
      mask_d[old_q[head1]] = 1'b1;

    head_d  = head_q + IDX_W'(cnt_d);
    tail_d  = tail_q + IDX_W'(alloc_ok);
    count_d = count_q
            + (IDX_W+1)'(alloc_ok)
            - (IDX_W+1)'(cnt_d);
  end

  // completion, then retire clear, then alloc
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (rob_if.cmpl0_valid
        && valid_q[rob_if.cmpl0_idx])
      done_d[rob_if.cmpl0_idx] = 1'b1;
    if (rob_if.cmpl1_valid
        && valid_q[rob_if.cmpl1_idx])
      done_d[rob_if.cmpl1_idx] = 1'b1;
    if (r0) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (r1) begin
      valid_d[head1] = 1'b0;
      done_d[head1]  = 1'b0;
    end
    if (alloc_ok) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      dr0_q   <= '0;
      dr1_q   <= '0;
      mask_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      dr0_q   <= dr0_d;
      dr1_q   <= dr1_d;
      mask_q  <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      hasd_q[tail_q] <= rob_if.alloc_has_dest;
      dr_q[tail_q]   <= rob_if.alloc_dr_p;
      old_q[tail_q]  <= rob_if.alloc_old_dr;
    end
  end

  assign rob_if.alloc_ready   = (count_q != FULL);
  assign rob_if.alloc_rob_num = tail_q;
  assign rob_if.rob_empty     = (count_q == '0);
  assign rob_if.retire_cnt    = cnt_q;
  assign rob_if.retire_dr_p0  = dr0_q;
  assign rob_if.retire_dr_p1  = dr1_q;
  assign rob_if.ROB_retire    = mask_q;
endmodule

// File: tb/tb_rob_retire_unit.sv
// Directed and random bench for rob_retire_unit against
// a program-order queue model of the buffer.
module tb_rob_retire_unit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  rob_retire_unit_if #(.IDX_W(4), .PREG_W(6)) bus ();

  rob_retire_unit #(
    .DEPTH(16), .IDX_W(4), .PREG_W(6)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rob_if(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int dr;
    int old;
    bit hasd;
    bit done;
  } ent_t;

  ent_t q[$];
  int m_tail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alloc_valid    = 1'b0;
    bus.alloc_has_dest = 1'b0;
    bus.alloc_dr_p     = '0;
    bus.alloc_old_dr   = '0;
    bus.cmpl0_valid    = 1'b0;
    bus.cmpl0_idx      = '0;
    bus.cmpl1_valid    = 1'b0;
    bus.cmpl1_idx      = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.alloc_valid = 1'b1;
    bus.alloc_has_dest = 1'b1;
    bus.alloc_dr_p = 6'd50;
    bus.alloc_old_dr = 6'd51;
    bus.cmpl0_valid = 1'b1;
    bus.cmpl0_idx = 4'd0;
    @(posedge clk);
    #1;
    q.delete();
    m_tail = 0;
    chk("rst_cnt", bus.retire_cnt, 0);
    chk("rst_dr0", bus.retire_dr_p0, 0);
    chk("rst_dr1", bus.retire_dr_p1, 0);
    chk("rst_mask", bus.ROB_retire, 0);
    chk("rst_ready", bus.alloc_ready, 1);
    chk("rst_num", bus.alloc_rob_num, 0);
    chk("rst_empty", bus.rob_empty, 1);
    rstn = 1'b1;
    idle_inputs();
  endtask

  task automatic step(input bit av, input bit hd,
                      input int dr, input int od,
                      input bit c0v, input int c0i,
                      input bit c1v, input int c1i);
    bit r0, r1, ok;
    int e_cnt, e_dr0, e_dr1;
    logic [63:0] e_mask;
    bus.alloc_valid    = av;
    bus.alloc_has_dest = hd;
    bus.alloc_dr_p     = 6'(dr);
    bus.alloc_old_dr   = 6'(od);
    bus.cmpl0_valid    = c0v;
    bus.cmpl0_idx      = 4'(c0i);
    bus.cmpl1_valid    = c1v;
    bus.cmpl1_idx      = 4'(c1i);
    ok = (q.size() != 16);
    chk("ready_pre", bus.alloc_ready, ok);
    r0 = (q.size() > 0) && q[0].done;
    r1 = r0 && (q.size() > 1) && q[1].done;
    e_cnt = int'(r0) + int'(r1);
    e_dr0 = r0 ? q[0].dr : 0;
    e_dr1 = r1 ? q[1].dr : 0;
    e_mask = '0;
    if (r0 && q[0].hasd && q[0].old != 0)
      e_mask[q[0].old] = 1'b1;
    if (r1 && q[1].hasd && q[1].old != 0)
      e_mask[q[1].old] = 1'b1;
    for (int k = 0; k < e_cnt; k++)
      void'(q.pop_front());
    foreach (q[k]) begin
      if (c0v && q[k].idx == c0i) q[k].done = 1;
      if (c1v && q[k].idx == c1i) q[k].done = 1;
    end
    if (av && ok) begin
      q.push_back('{m_tail, dr, od, hd, 1'b0});
      m_tail = (m_tail + 1) % 16;
    end
    @(posedge clk);
    #1;
    chk("cnt", bus.retire_cnt, e_cnt);
    chk("dr0", bus.retire_dr_p0, e_dr0);
    chk("dr1", bus.retire_dr_p1, e_dr1);
    chk("mask", bus.ROB_retire, e_mask);
    chk("ready", bus.alloc_ready, q.size() != 16);
    chk("num", bus.alloc_rob_num, m_tail);
    chk("empty", bus.rob_empty, q.size() == 0);
    idle_inputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // three allocs, out-of-order completion, dual retire
    step(1, 1, 33, 5, 0, 0, 0, 0);
    step(1, 1, 34, 6, 0, 0, 0, 0);
    step(1, 1, 35, 7, 0, 0, 0, 0);
    chk("s1_num", bus.alloc_rob_num, 3);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("s1_nor", bus.retire_cnt, 0);
    idle();
    chk("s1_cnt", bus.retire_cnt, 2);
    chk("s1_dr0", bus.retire_dr_p0, 33);
    chk("s1_dr1", bus.retire_dr_p1, 34);
    chk("s1_mask", bus.ROB_retire, 64'h60);

    // fill to full, extra alloc ignored
    do_reset();
    for (int i = 0; i < 16; i++)
      step(1, 1, 20 + i, 1 + i, 0, 0, 0, 0);
    chk("full_rdy", bus.alloc_ready, 0);
    step(1, 1, 60, 61, 0, 0, 0, 0);
    chk("full_num", bus.alloc_rob_num, 0);
    step(1, 1, 60, 61, 1, 0, 0, 0);
    step(1, 1, 60, 61, 0, 0, 0, 0);
    chk("full_ret", bus.retire_cnt, 1);
    step(1, 1, 62, 63, 0, 0, 0, 0);

    // store and old_dr==0 free nothing
    do_reset();
    step(1, 0, 0, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    chk("st_cnt", bus.retire_cnt, 1);
    chk("st_mask", bus.ROB_retire, 0);
    step(1, 1, 12, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    chk("z_mask", bus.ROB_retire, 0);

    // dual retire straddling 15 -> 0
    do_reset();
    for (int i = 0; i < 15; i++)
      step(1, 1, i + 1, i + 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 0, 1, 2 * i, 1, 2 * i + 1);
    repeat (10) idle();
    chk("w_num15", bus.alloc_rob_num, 15);
    step(1, 1, 40, 41, 0, 0, 0, 0);
    step(1, 1, 42, 43, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 15, 1, 0);
    idle();
    chk("w_cnt", bus.retire_cnt, 2);
    chk("w_empty", bus.rob_empty, 1);
    chk("w_num", bus.alloc_rob_num, 1);

    // same-index dual completion, invalid index
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1, 1, 30 + i, 10 + i, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 1, 3);
    step(0, 0, 0, 0, 1, 10, 0, 0);
    idle();
    chk("c_nor", bus.retire_cnt, 0);
    step(0, 0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1, 2, 0, 0);
    repeat (3) idle();

    // reset with entries in flight
    for (int i = 0; i < 5; i++)
      step(1, 1, 44 + i, 20 + i, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4, 1, 5);
    do_reset();
    idle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit av, c0v, c1v;
      int c0i, c1i;
      av  = ($urandom_range(0, 9) < 7);
      c0v = $urandom_range(0, 1);
      c1v = $urandom_range(0, 2) == 0;
      c0i = $urandom_range(0, 15);
      c1i = $urandom_range(0, 15);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        c0i = q[$urandom_range(0, q.size() - 1)].idx;
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        c1i = q[$urandom_range(0, q.size() - 1)].idx;
      if (n % 150 == 75) begin
        do_reset();
      end else begin
        step(av, $urandom_range(0, 3) != 0,
             $urandom_range(0, 63),
             $urandom_range(0, 63),
             c0v, c0i, c1v, c1i);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
